taxi_ram_2rw_1c_pipe: RTL and testbench



---
 rtl/taxi_ram_pkg.sv | 14 +
 rtl/taxi_ram_rd_pipe.sv | 50 +++++
 rtl/taxi_ram_2rw_1c_pipe.sv | 150 +++++++++++++++
 tb/tb_taxi_ram_2rw_1c_pipe.sv | 225 ++++++++++++++++++++++
 4 files changed

// File: rtl/taxi_ram_pkg.sv
// Shared types and limits for the taxi_ram family.
package taxi_ram_pkg;

  // Read-side behaviour of a port when it performs a write.
  typedef enum logic [1:0] {
    WR_MODE_READ_FIRST  = 2'd0,
    WR_MODE_WRITE_FIRST = 2'd1,
    WR_MODE_NO_CHANGE   = 2'd2
  } wr_mode_t;

  // Deepest supported read pipeline (array register plus three delay stages).
  localparam int RD_LAT_MAX = 4;

endpackage

// File: rtl/taxi_ram_rd_pipe.sv
// Per-port read delay line: STAGES data+valid registers behind the array read
// register. Data only advances with its valid bit, so the output word holds
// between strobes. Valid bits and data clear synchronously on rst.
module taxi_ram_rd_pipe #(
  parameter int DATA_W = 16,
  parameter int STAGES = 0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_vld,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_vld,
  output logic [DATA_W-1:0] out_data
);

  if (STAGES == 0) begin : g_bypass
    assign out_vld  = in_vld;
    assign out_data = in_data;
  end else begin : g_stages
    logic [STAGES-1:0] vld_d, vld_q;
    logic [DATA_W-1:0] data_d [STAGES];
    logic [DATA_W-1:0] data_q [STAGES];

    // Shift valid every cycle; move data only alongside a valid bit.
    always_comb begin
      vld_d  = vld_q;
      data_d = data_q;
      vld_d[0] = in_vld;
      if (in_vld) data_d[0] = in_data;
      for (int i = 1; i < STAGES; i++) begin
        vld_d[i] = vld_q[i-1];
        if (vld_q[i-1]) data_d[i] = data_q[i-1];
      end
      if (rst) begin
        vld_d = '0;
        for (int i = 0; i < STAGES; i++) data_d[i] = '0;
      end
    end

    // Delay-line registers.
    always_ff @(posedge clk) begin
      vld_q  <= vld_d;
      data_q <= data_d;
    end

    assign out_vld  = vld_q[STAGES-1];
    assign out_data = data_q[STAGES-1];
  end

endmodule

// File: rtl/taxi_ram_2rw_1c_pipe.sv
// True dual-port single-clock RAM with RD_LAT-cycle registered reads,
// per-port read-during-write mode, read-valid strobes and defined
// same-address cross-port behaviour (port A wins shared write lanes,
// reads always see the pre-write word).
// Optional macro TAXI_RAM_COLLISION_DET_EN builds the same-address
// collision flags; without it both collision outputs are tied low.
module taxi_ram_2rw_1c_pipe
  import taxi_ram_pkg::*;
#(
  parameter int       ADDR_W    = 16,
  parameter int       DATA_W    = 16,
  parameter bit       STRB_EN   = 1'b1,
  parameter int       STRB_W    = DATA_W / 8,
  parameter int       RD_LAT    = 1,
  parameter wr_mode_t A_WR_MODE = WR_MODE_READ_FIRST,
  parameter wr_mode_t B_WR_MODE = WR_MODE_READ_FIRST
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              a_en,
  input  logic [ADDR_W-1:0] a_addr,
  input  logic              a_wr_en,
  input  logic [DATA_W-1:0] a_wr_data,
  input  logic [STRB_W-1:0] a_wr_strb,
  output logic [DATA_W-1:0] a_rd_data,
  output logic              a_rd_valid,
  output logic              a_collision,
  input  logic              b_en,
  input  logic [ADDR_W-1:0] b_addr,
  input  logic              b_wr_en,
  input  logic [DATA_W-1:0] b_wr_data,
  input  logic [STRB_W-1:0] b_wr_strb,
  output logic [DATA_W-1:0] b_rd_data,
  output logic              b_rd_valid,
  output logic              b_collision
);

  // With strobes disabled the whole word is a single lane.
  localparam int NLANE  = STRB_EN ? STRB_W : 1;
  localparam int LANE_W = DATA_W / ((NLANE > 0) ? NLANE : 1);
  localparam int DEPTH  = 2 ** ADDR_W;

  if (RD_LAT < 1 || RD_LAT > RD_LAT_MAX) begin : g_bad_lat
    $fatal(1, "taxi_ram_2rw_1c_pipe: RD_LAT=%0d outside 1..%0d", RD_LAT, RD_LAT_MAX);
  end
  if (STRB_EN && (NLANE < 1 || NLANE * LANE_W != DATA_W)) begin : g_bad_strb
    $fatal(1, "taxi_ram_2rw_1c_pipe: DATA_W=%0d not divisible into STRB_W=%0d lanes", DATA_W, STRB_W);
  end

  // Replace the lanes selected by strb with new_w, keep old_w elsewhere.
  function automatic logic [DATA_W-1:0] merge_lanes(input logic [DATA_W-1:0] old_w,
                                                    input logic [DATA_W-1:0] new_w,
                                                    input logic [NLANE-1:0]  strb);
    merge_lanes = old_w;
    for (int i = 0; i < NLANE; i++) begin
      if (strb[i]) merge_lanes[i*LANE_W +: LANE_W] = new_w[i*LANE_W +: LANE_W];
    end
  endfunction

  logic [DATA_W-1:0] mem [DEPTH] = '{default: '0};

  logic [NLANE-1:0]  a_strb_eff, b_strb_eff;
  logic              a_we, b_we, same_addr;
  logic [DATA_W-1:0] a_old, b_old, a_own_word, b_own_word, a_wr_word;

  assign a_strb_eff = STRB_EN ? a_wr_strb[NLANE-1:0] : '1;
  assign b_strb_eff = STRB_EN ? b_wr_strb[NLANE-1:0] : '1;
  assign a_we       = a_en & a_wr_en & ~rst;
  assign b_we       = b_en & b_wr_en & ~rst;
  assign same_addr  = (a_addr == b_addr);
  assign a_old      = mem[a_addr];
  assign b_old      = mem[b_addr];
  assign a_own_word = merge_lanes(a_old, a_wr_data, a_strb_eff);
  assign b_own_word = merge_lanes(b_old, b_wr_data, b_strb_eff);
  // On a same-address double write, A layers its lanes over B's merged word
  // and, being written last, carries the combined result into the array.
  assign a_wr_word  = merge_lanes((b_we && same_addr) ? b_own_word : a_old, a_wr_data, a_strb_eff);

  // Array write port; A's assignment follows B's so A wins on a shared address.
  always_ff @(posedge clk) begin
    if (b_we) mem[b_addr] <= b_own_word;
    if (a_we) mem[a_addr] <= a_wr_word;
  end

  // ---- stage 1: array read register ----
  logic              a_vld_p1_d, a_vld_p1_q, b_vld_p1_d, b_vld_p1_q;
  logic [DATA_W-1:0] a_data_p1_d, a_data_p1_q, b_data_p1_d, b_data_p1_q;

  // Select old or merged word per mode; NO_CHANGE writes produce no strobe.
  always_comb begin
    a_vld_p1_d  = a_en & ~rst & ~(a_wr_en & (A_WR_MODE == WR_MODE_NO_CHANGE));
    b_vld_p1_d  = b_en & ~rst & ~(b_wr_en & (B_WR_MODE == WR_MODE_NO_CHANGE));
    a_data_p1_d = a_data_p1_q;
    b_data_p1_d = b_data_p1_q;
    if (a_vld_p1_d) a_data_p1_d = (a_wr_en && A_WR_MODE == WR_MODE_WRITE_FIRST) ? a_own_word : a_old;
    if (b_vld_p1_d) b_data_p1_d = (b_wr_en && B_WR_MODE == WR_MODE_WRITE_FIRST) ? b_own_word : b_old;
    if (rst) begin
      a_data_p1_d = '0;
      b_data_p1_d = '0;
    end
  end

  // Stage-1 registers.
  always_ff @(posedge clk) begin
    a_vld_p1_q  <= a_vld_p1_d;
    b_vld_p1_q  <= b_vld_p1_d;
    a_data_p1_q <= a_data_p1_d;
    b_data_p1_q <= b_data_p1_d;
  end

  // ---- stages 2..RD_LAT: plain delay registers ----
  taxi_ram_rd_pipe #(.DATA_W(DATA_W), .STAGES(RD_LAT - 1)) u_a_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (a_vld_p1_q),
    .in_data (a_data_p1_q),
    .out_vld (a_rd_valid),
    .out_data(a_rd_data)
  );

  taxi_ram_rd_pipe #(.DATA_W(DATA_W), .STAGES(RD_LAT - 1)) u_b_pipe (
    .clk     (clk),
    .rst     (rst),
    .in_vld  (b_vld_p1_q),
    .in_data (b_data_p1_q),
    .out_vld (b_rd_valid),
    .out_data(b_rd_data)
  );

`ifdef TAXI_RAM_COLLISION_DET_EN
  logic coll_d, coll_q;

  // Flag any same-address cycle where both ports are active and one writes.
  always_comb begin
    coll_d = ~rst & a_en & b_en & same_addr & (a_wr_en | b_wr_en);
  end

  // Collision register, one-cycle pulse.
  always_ff @(posedge clk) begin
    coll_q <= coll_d;
  end

  assign a_collision = coll_q;
  assign b_collision = coll_q;
`else
  assign a_collision = 1'b0;
  assign b_collision = 1'b0;
`endif

endmodule

// File: tb/tb_taxi_ram_2rw_1c_pipe.sv
// Scoreboard bench for taxi_ram_2rw_1c_pipe. Two instances share one stimulus:
// dut0 RD_LAT=3 (A READ_FIRST, B WRITE_FIRST), dut1 RD_LAT=4 (A NO_CHANGE,
// B READ_FIRST). A word-level reference memory predicts every read strobe.
module tb_taxi_ram_2rw_1c_pipe;
  import taxi_ram_pkg::*;

  localparam int AW = 4;
  localparam int DW = 32;
  localparam int SW = 4;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1;
  logic          a_en = 1'b0, a_wr_en = 1'b0, b_en = 1'b0, b_wr_en = 1'b0;
  logic [AW-1:0] a_addr = '0, b_addr = '0;
  logic [DW-1:0] a_wr_data = '0, b_wr_data = '0;
  logic [SW-1:0] a_wr_strb = '1, b_wr_strb = '1;

  // Channel c: 0 dut0.A, 1 dut0.B, 2 dut1.A, 3 dut1.B
  logic [DW-1:0] rd_data [4];
  logic          rd_valid[4];
  logic          coll    [4];

  taxi_ram_2rw_1c_pipe #(.ADDR_W(AW), .DATA_W(DW), .STRB_EN(1'b1), .STRB_W(SW), .RD_LAT(3),
    .A_WR_MODE(WR_MODE_READ_FIRST), .B_WR_MODE(WR_MODE_WRITE_FIRST)) dut0 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_addr(a_addr), .a_wr_en(a_wr_en), .a_wr_data(a_wr_data), .a_wr_strb(a_wr_strb),
    .a_rd_data(rd_data[0]), .a_rd_valid(rd_valid[0]), .a_collision(coll[0]),
    .b_en(b_en), .b_addr(b_addr), .b_wr_en(b_wr_en), .b_wr_data(b_wr_data), .b_wr_strb(b_wr_strb),
    .b_rd_data(rd_data[1]), .b_rd_valid(rd_valid[1]), .b_collision(coll[1]));

  taxi_ram_2rw_1c_pipe #(.ADDR_W(AW), .DATA_W(DW), .STRB_EN(1'b1), .STRB_W(SW), .RD_LAT(4),
    .A_WR_MODE(WR_MODE_NO_CHANGE), .B_WR_MODE(WR_MODE_READ_FIRST)) dut1 (
    .clk(clk), .rst(rst),
    .a_en(a_en), .a_addr(a_addr), .a_wr_en(a_wr_en), .a_wr_data(a_wr_data), .a_wr_strb(a_wr_strb),
    .a_rd_data(rd_data[2]), .a_rd_valid(rd_valid[2]), .a_collision(coll[2]),
    .b_en(b_en), .b_addr(b_addr), .b_wr_en(b_wr_en), .b_wr_data(b_wr_data), .b_wr_strb(b_wr_strb),
    .b_rd_data(rd_data[3]), .b_rd_valid(rd_valid[3]), .b_collision(coll[3]));

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          exp_q[4][$];
  logic [DW-1:0] ref_mem[16];
  logic [DW-1:0] last_data[4];
  int            lat_c[4]  = '{3, 3, 4, 4};
  wr_mode_t      mode_c[4] = '{WR_MODE_READ_FIRST, WR_MODE_WRITE_FIRST, WR_MODE_NO_CHANGE, WR_MODE_READ_FIRST};
  int            cyc = 0;
  bit            rst_edge = 1'b1;
  bit            coll_exp = 1'b0;
  int            n_cmp = 0;
  int            n_bad = 0;

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = '0;
    for (int i = 0; i < 4; i++) last_data[i] = '0;
  end

  // Byte-lane write rule: bytes with strobe set take the new value.
  function automatic logic [DW-1:0] byte_write(input logic [DW-1:0] old_w, input logic [DW-1:0] new_w,
                                               input logic [SW-1:0] strb);
    logic [DW-1:0] r;
    r = old_w;
    for (int k = 0; k < SW; k++) if (strb[k]) r[8*k +: 8] = new_w[8*k +: 8];
    return r;
  endfunction

  task automatic chk(input string name, input int c, input logic [DW-1:0] act, input logic [DW-1:0] req);
    n_cmp++;
    if (act !== req) begin
      n_bad++;
      $display("FAIL %s ch%0d cyc%0d: got %h, expected %h", name, c, cyc, act, req);
    end
  endtask

  // Reference model: observes each sampled access and predicts its read result.
  always @(posedge clk) begin : p_model
    int            edge_n;
    logic          en, wr;
    logic [DW-1:0] old_w, new_w;
    exp_t          e;
    edge_n = cyc + 1;
    cyc <= cyc + 1;
    rst_edge = rst;
    if (rst) begin
      for (int c = 0; c < 4; c++) exp_q[c].delete();
      coll_exp = 1'b0;
    end else begin
`ifdef TAXI_RAM_COLLISION_DET_EN
      coll_exp = a_en && b_en && (a_addr == b_addr) && (a_wr_en || b_wr_en);
`else
      coll_exp = 1'b0;
`endif
      for (int c = 0; c < 4; c++) begin
        en    = (c % 2 == 0) ? a_en : b_en;
        wr    = (c % 2 == 0) ? a_wr_en : b_wr_en;
        old_w = (c % 2 == 0) ? ref_mem[a_addr] : ref_mem[b_addr];
        new_w = (c % 2 == 0) ? byte_write(old_w, a_wr_data, a_wr_strb) : byte_write(old_w, b_wr_data, b_wr_strb);
        e.due = edge_n + lat_c[c] - 1;
        if (en && !wr) begin
          e.data = old_w;
          exp_q[c].push_back(e);
        end else if (en && wr && mode_c[c] != WR_MODE_NO_CHANGE) begin
          e.data = (mode_c[c] == WR_MODE_WRITE_FIRST) ? new_w : old_w;
          exp_q[c].push_back(e);
        end
      end
      // B lands first, then A on top, so A owns lanes both ports strobe.
      if (b_en && b_wr_en) ref_mem[b_addr] = byte_write(ref_mem[b_addr], b_wr_data, b_wr_strb);
      if (a_en && a_wr_en) ref_mem[a_addr] = byte_write(ref_mem[a_addr], a_wr_data, a_wr_strb);
    end
  end

  // Monitor: compares DUT outputs mid-cycle against the scoreboard.
  always @(negedge clk) begin : p_mon
    exp_t e;
    for (int c = 0; c < 4; c++) begin
      if (rst_edge) begin
        chk("reset_valid", c, {31'b0, rd_valid[c]}, '0);
        chk("reset_data", c, rd_data[c], '0);
        last_data[c] = '0;
      end else if (rd_valid[c]) begin
        if (exp_q[c].size() == 0) begin
          n_cmp++;
          n_bad++;
          $display("FAIL unexpected_valid ch%0d cyc%0d: got data %h, expected no strobe", c, cyc, rd_data[c]);
          last_data[c] = rd_data[c];
        end else begin
          e = exp_q[c].pop_front();
          chk("latency", c, cyc, e.due);
          chk("rd_data", c, rd_data[c], e.data);
          last_data[c] = e.data;
        end
      end else begin
        chk("hold", c, rd_data[c], last_data[c]);
        if (exp_q[c].size() > 0 && exp_q[c][0].due <= cyc) begin
          e = exp_q[c].pop_front();
          n_cmp++;
          n_bad++;
          $display("FAIL missing_valid ch%0d cyc%0d: got no strobe, expected %h due cyc%0d", c, cyc, e.data, e.due);
        end
      end
      chk("collision", c, {31'b0, coll[c]}, {31'b0, coll_exp});
    end
  end

  task automatic drv(input logic ae, input logic aw, input logic [AW-1:0] aa, input logic [DW-1:0] ad,
                     input logic [SW-1:0] as, input logic be, input logic bw, input logic [AW-1:0] ba,
                     input logic [DW-1:0] bd, input logic [SW-1:0] bs);
    a_en = ae; a_wr_en = aw; a_addr = aa; a_wr_data = ad; a_wr_strb = as;
    b_en = be; b_wr_en = bw; b_addr = ba; b_wr_data = bd; b_wr_strb = bs;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    repeat (n) drv(1'b0, 1'b0, '0, '0, '1, 1'b0, 1'b0, '0, '0, '1);
  endtask

  initial begin : p_watchdog
    #1000000;
    $display("FAIL watchdog: simulation exceeded time budget");
    $fatal(1, "watchdog");
  end

  initial begin : p_stim
    rst = 1'b1;
    idle(3);
    rst = 1'b0;
    // Latency: write A[5], read it from B a few cycles later
    drv(1, 1, 4'd5, 32'h11223344, 4'hF, 0, 0, '0, '0, '1);
    idle(2);
    drv(0, 0, '0, '0, '1, 1, 0, 4'd5, '0, '1);
    idle(6);
    // Mode sweep on both ports
    drv(1, 1, 4'd2, 32'hAAAAAAAA, 4'hF, 0, 0, '0, '0, '1);
    drv(1, 1, 4'd2, 32'h55555555, 4'b0011, 0, 0, '0, '0, '1);
    drv(0, 0, '0, '0, '1, 1, 1, 4'd2, 32'hAAAAAAAA, 4'hF);
    drv(0, 0, '0, '0, '1, 1, 1, 4'd2, 32'h55555555, 4'b0011);
    drv(1, 0, 4'd2, '0, '1, 0, 0, '0, '0, '1);
    idle(6);
    // Write/write collision, full and partial lane overlap
    drv(1, 1, 4'd7, 32'h11111111, 4'hF, 1, 1, 4'd7, 32'h22222222, 4'hC);
    drv(1, 0, 4'd7, '0, '1, 1, 0, 4'd7, '0, '1);
    drv(1, 1, 4'd8, 32'h11111111, 4'h3, 1, 1, 4'd8, 32'h22222222, 4'hE);
    drv(1, 0, 4'd8, '0, '1, 0, 0, '0, '0, '1);
    idle(6);
    // Read/write collision
    drv(1, 1, 4'd3, 32'h0, 4'hF, 0, 0, '0, '0, '1);
    drv(1, 1, 4'd3, 32'hDEADBEEF, 4'hF, 1, 0, 4'd3, '0, '1);
    drv(0, 0, '0, '0, '1, 1, 0, 4'd3, '0, '1);
    idle(6);
    // Reset with reads in flight, then a read right after release
    for (int i = 0; i < 3; i++) drv(1, 0, AW'(i), '0, '1, 1, 0, AW'(i + 4), '0, '1);
    rst = 1'b1;
    drv(1, 0, 4'd1, '0, '1, 1, 0, 4'd1, '0, '1);
    rst = 1'b0;
    drv(1, 0, 4'd5, '0, '1, 1, 0, 4'd7, '0, '1);
    idle(6);
    // Back-to-back streaming on both ports
    for (int i = 0; i < 16; i++) drv(1, 0, AW'(i), '0, '1, 1, 0, AW'(15 - i), '0, '1);
    idle(6);
    // Randomised traffic with occasional reset
    repeat (1500) begin
      rst = ($urandom_range(0, 99) == 0);
      drv(($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom, SW'($urandom),
          ($urandom_range(0, 3) != 0), $urandom_range(0, 1), AW'($urandom_range(0, 15)), $urandom, SW'($urandom));
    end
    rst = 1'b0;
    idle(8);
    for (int c = 0; c < 4; c++) begin
      n_cmp++;
      if (exp_q[c].size() != 0) begin
        n_bad++;
        $display("FAIL drain ch%0d: got %0d pending reads, expected 0", c, exp_q[c].size());
      end
    end
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
